cali_rls_seq: RTL and testbench

// - Calibration sequencer for the piecewise DCD-RLS/LMS distortion-calibration datapath.
// - Drives the datapath's EN, CALI_MODE_RLS, PSEGS and a local active-low LUT clear.
// - Run order: clear -> RLS acquisition until converged or timed out -> LMS tracking.
// - During tracking it monitors |ERR| and re-acquires automatically on loss of lock.

---
 rtl/cali_rls_seq.sv | 180 ++++++++++++++++++
 tb/tb_cali_rls_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cali_rls_seq.sv
// rtl/cali_rls_seq.sv - calibration sequencer for the DCD-RLS/LMS distortion-calibration datapath
// Runs clear -> RLS acquisition -> LMS tracking and re-acquires on loss of lock.
module cali_rls_seq #(
  parameter int ERR_W    = 16,
  parameter int WIN_LOG2 = 4,
  parameter int CLR_CYC  = 4,
  parameter int ACQ_MAXW = 64,
  parameter int LOST_N   = 3
) (
  input  logic                      CLK,
  input  logic                      NRST,
  input  logic                      START,
  input  logic                      STOP,
  input  logic                      HOLD,
  input  logic [1:0]                PSEGS_CFG,
  input  logic [ERR_W+WIN_LOG2-1:0] THR_ACQ,
  input  logic [ERR_W+WIN_LOG2-1:0] THR_LOST,
  input  logic [ERR_W-1:0]          ERR_Q,
  output logic                      CALI_NRST,
  output logic                      CALI_EN,
  output logic                      CALI_MODE_RLS,
  output logic [1:0]                PSEGS,
  output logic                      BUSY,
  output logic                      LOCKED,
  output logic                      ACQ_TMO,
  output logic [7:0]                RELOCK_CNT
);

  localparam int ACC_W = ERR_W + WIN_LOG2;
  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int WN_W  = $clog2(ACQ_MAXW + 1);
  localparam int BN_W  = $clog2(LOST_N + 1);

  typedef enum logic [1:0] {IDLE, CLR, ACQ, TRACK} state_t;

  state_t           state, state_n;
  logic [CLR_W-1:0] clr_cnt;
  logic [ACC_W-1:0] acc;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [WN_W-1:0]  win_n, win_n_nx;
  logic [BN_W-1:0]  bad_n, bad_n_nx;
  logic [1:0]       psegs_r;
  logic             acq_tmo_r;
  logic [7:0]       relock_r;
  logic             cali_nrst_r;

  logic             active;
  logic             en;
  logic             win_end;
  logic [ERR_W-1:0] err_abs;
  logic [ACC_W-1:0] win_sum;
  logic             do_start;
  logic             tmo_set;
  logic             relock_inc;

  // |ERR_Q| with the most negative code clamped so it fits in ERR_W-1 magnitude bits
  always_comb begin
    err_abs = ERR_Q;
    if (ERR_Q[ERR_W-1]) begin
      if (ERR_Q == {1'b1, {(ERR_W-1){1'b0}}})
        err_abs = {1'b0, {(ERR_W-1){1'b1}}};
      else
        err_abs = -ERR_Q;
    end
  end

  assign active  = (state == ACQ) || (state == TRACK);
  assign en      = active && !HOLD;
  assign win_sum = acc + {{WIN_LOG2{1'b0}}, err_abs};
  assign win_end = en && (win_cnt == '1);

  always_comb begin
    state_n    = state;
    do_start   = 1'b0;
    tmo_set    = 1'b0;
    relock_inc = 1'b0;
    win_n_nx   = win_n;
    bad_n_nx   = bad_n;
    if (STOP) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state_n  = CLR;
            do_start = 1'b1;
          end
        end
        CLR: begin
          if (clr_cnt == CLR_W'(CLR_CYC - 1))
            state_n = ACQ;
        end
        ACQ: begin
          if (win_end) begin
            if (win_sum < THR_ACQ) begin
              state_n = TRACK;
            end else begin
              win_n_nx = win_n + WN_W'(1);
              if (win_n_nx == WN_W'(ACQ_MAXW)) begin
                tmo_set = 1'b1;
                state_n = TRACK;
              end
            end
          end
        end
        TRACK: begin
          if (win_end) begin
            if (win_sum > THR_LOST) begin
              bad_n_nx = bad_n + BN_W'(1);
              if (bad_n_nx == BN_W'(LOST_N)) begin
                relock_inc = 1'b1;
                state_n    = CLR;
              end
            end else begin
              bad_n_nx = '0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      acc         <= '0;
      win_cnt     <= '0;
      win_n       <= '0;
      bad_n       <= '0;
      psegs_r     <= 2'd0;
      acq_tmo_r   <= 1'b0;
      relock_r    <= 8'd0;
      cali_nrst_r <= 1'b0;
    end else begin
      state       <= state_n;
      cali_nrst_r <= (state_n != CLR);

      if (state == CLR && state_n == CLR)
        clr_cnt <= clr_cnt + CLR_W'(1);
      else
        clr_cnt <= '0;

      // Monitor restarts on every state change; HOLD freezes it in place
      if (state_n != state || !active) begin
        acc     <= '0;
        win_cnt <= '0;
        win_n   <= '0;
        bad_n   <= '0;
      end else if (en) begin
        win_cnt <= win_cnt + WIN_LOG2'(1);
        acc     <= win_end ? '0 : win_sum;
        win_n   <= win_n_nx;
        bad_n   <= bad_n_nx;
      end

      if (do_start) begin
        psegs_r   <= PSEGS_CFG;
        acq_tmo_r <= 1'b0;
        relock_r  <= 8'd0;
      end else begin
        if (tmo_set)
          acq_tmo_r <= 1'b1;
        if (relock_inc && relock_r != 8'hFF)
          relock_r <= relock_r + 8'd1;
      end
    end
  end

  assign CALI_NRST     = cali_nrst_r;
  assign CALI_EN       = en;
  assign CALI_MODE_RLS = (state != TRACK);
  assign PSEGS         = psegs_r;
  assign BUSY          = (state != IDLE);
  assign LOCKED        = (state == TRACK);
  assign ACQ_TMO       = acq_tmo_r;
  assign RELOCK_CNT    = relock_r;

endmodule

// File: tb/tb_cali_rls_seq.sv
// tb/tb_cali_rls_seq.sv - scoreboard bench for cali_rls_seq
// Expected output transitions are queued with their cycle; a monitor checks each observed change.
module tb_cali_rls_seq;

  logic        CLK = 1'b0;
  logic        NRST = 1'b1;
  logic        START, STOP, HOLD;
  logic [1:0]  PSEGS_CFG;
  logic [19:0] THR_ACQ, THR_LOST;
  logic [15:0] ERR_Q;
  logic        CALI_NRST, CALI_EN, CALI_MODE_RLS, BUSY, LOCKED, ACQ_TMO;
  logic [1:0]  PSEGS;
  logic [7:0]  RELOCK_CNT;

  cali_rls_seq dut (
    .CLK(CLK), .NRST(NRST), .START(START), .STOP(STOP), .HOLD(HOLD),
    .PSEGS_CFG(PSEGS_CFG), .THR_ACQ(THR_ACQ), .THR_LOST(THR_LOST), .ERR_Q(ERR_Q),
    .CALI_NRST(CALI_NRST), .CALI_EN(CALI_EN), .CALI_MODE_RLS(CALI_MODE_RLS),
    .PSEGS(PSEGS), .BUSY(BUSY), .LOCKED(LOCKED), .ACQ_TMO(ACQ_TMO),
    .RELOCK_CNT(RELOCK_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [15:0] snap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  wire [15:0] snap = {CALI_NRST, CALI_EN, CALI_MODE_RLS, PSEGS, BUSY, LOCKED, ACQ_TMO, RELOCK_CNT};

  function automatic logic [15:0] mk(input logic n, input logic e, input logic m,
                                     input logic [1:0] p, input logic b, input logic l,
                                     input logic t, input logic [7:0] r);
    return {n, e, m, p, b, l, t, r};
  endfunction

  task automatic push_exp(input int dc, input logic [15:0] s);
    exp_t e;
    e.at   = cyc + dc;
    e.snap = s;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s got=%h want=%h cyc=%0d", name, got, want, cyc);
  endtask

  // Output monitor: every change of the observed output vector must match the next queued event
  logic [15:0] prev = 16'h2000;
  always @(negedge CLK) begin
    if (snap !== prev) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_change got=%h cyc=%0d", snap, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (snap === e.snap && cyc == e.at) passed++;
        else $display("FAIL event got=%h@%0d want=%h@%0d", snap, cyc, e.snap, e.at);
      end
      prev = snap;
    end
  end

  initial begin
    START = 0; STOP = 0; HOLD = 0; PSEGS_CFG = 0;
    THR_ACQ = 20'd40; THR_LOST = 20'd1000; ERR_Q = 16'd2;
    #1 NRST = 0;
    #3;
    chk("reset_outputs", snap, mk(0, 0, 1, 0, 0, 0, 0, 0));
    tick_n(2);
    NRST = 1;
    push_exp(1, mk(1, 0, 1, 0, 0, 0, 0, 0));
    tick_n(2);

    // Acquire with small error: converge on the first window
    PSEGS_CFG = 2'd3; START = 1;
    push_exp(1,  mk(0, 0, 1, 3, 1, 0, 0, 0));
    push_exp(5,  mk(1, 1, 1, 3, 1, 0, 0, 0));
    push_exp(21, mk(1, 1, 0, 3, 1, 1, 0, 0));
    tick(); START = 0; PSEGS_CFG = 2'd0;
    tick_n(20);
    chk("track_psegs", {14'd0, PSEGS}, 16'd3);

    // Most negative error in TRACK: three bad windows then re-clear
    ERR_Q = 16'h8000;
    push_exp(48, mk(0, 0, 1, 3, 1, 0, 0, 1));
    push_exp(52, mk(1, 1, 1, 3, 1, 0, 0, 1));
    tick_n(52);
    ERR_Q = 16'd100;
    push_exp(1024, mk(1, 1, 0, 3, 1, 1, 1, 1));
    tick_n(1024);
    ERR_Q = 16'd2;
    chk("relock_cnt", {8'd0, RELOCK_CNT}, 16'd1);
    tick_n(5);

    STOP = 1;
    push_exp(1, mk(1, 0, 1, 3, 0, 0, 1, 1));
    tick(); STOP = 0;
    chk("stop_busy", {15'd0, BUSY}, 16'd0);
    tick_n(3);

    // Restart, HOLD for 10 cycles mid-window; START and PSEGS_CFG ignored while busy
    PSEGS_CFG = 2'd1; START = 1;
    push_exp(1,  mk(0, 0, 1, 1, 1, 0, 0, 0));
    push_exp(5,  mk(1, 1, 1, 1, 1, 0, 0, 0));
    push_exp(10, mk(1, 0, 1, 1, 1, 0, 0, 0));
    push_exp(20, mk(1, 1, 1, 1, 1, 0, 0, 0));
    push_exp(31, mk(1, 1, 0, 1, 1, 1, 0, 0));
    tick(); START = 0; PSEGS_CFG = 2'd2;
    tick_n(9);
    HOLD = 1;
    tick_n(3); START = 1; tick(); START = 0;
    tick_n(6);
    HOLD = 0;
    tick_n(11);
    chk("hold_psegs", {14'd0, PSEGS}, 16'd1);
    tick_n(3);

    STOP = 1;
    push_exp(1, mk(1, 0, 1, 1, 0, 0, 0, 0));
    tick(); STOP = 0;
    tick_n(2);

    // START and STOP together in IDLE: nothing happens
    START = 1; STOP = 1;
    tick(); START = 0; STOP = 0;
    tick_n(3);
    chk("start_stop_idle", {14'd0, BUSY, CALI_NRST}, 16'd1);

    // Asynchronous reset in the middle of acquisition
    PSEGS_CFG = 2'd2; START = 1;
    push_exp(1, mk(0, 0, 1, 2, 1, 0, 0, 0));
    push_exp(5, mk(1, 1, 1, 2, 1, 0, 0, 0));
    tick(); START = 0;
    tick_n(6);
    push_exp(0, mk(0, 0, 1, 0, 0, 0, 0, 0));
    NRST = 0;
    tick_n(2);
    NRST = 1;
    push_exp(1, mk(1, 0, 1, 0, 0, 0, 0, 0));
    tick_n(4);

    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
